// File: rtl/noc_merge2_arb.sv
// noc_merge2_arb: clocked 2-to-1 flit merge with round-robin arbitration and a
// small FIFO. Each queued entry carries the flit plus the index of the input
// that delivered it. Flit format is unchanged: [8:5] address, [4:0] payload.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in0_valid/ready/data       input stream 0
//   in1_valid/ready/data       input stream 1
//   out_valid/ready/data       merged output stream (FIFO head)
//   out_src                    input index that delivered the head flit
//   stat0, stat1               (NOC_MERGE_STATS_EN only) saturating counts of
//                              flits accepted from in0 / in1
//
// Optional feature macro: NOC_MERGE_STATS_EN adds the stat0/stat1 counters.

module noc_merge2_arb #(
    parameter int unsigned W     = 9,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [W-1:0]     in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [W-1:0]     in1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_src
`ifdef NOC_MERGE_STATS_EN
    ,
    output logic [CNT_W-1:0] stat0,
    output logic [CNT_W-1:0] stat1
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be >= 1");
    end

    // Entry layout: {src, flit}
    logic [W:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          pri_q;

    logic          full;
    logic          empty;
    logic          gnt_valid;
    logic          gnt_idx;
    logic          push;
    logic          pop;
    logic [W-1:0]  push_data;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Grant: contested cycles go to pri, otherwise to whichever input is valid.
    always_comb begin
        gnt_valid = in0_valid | in1_valid;
        gnt_idx   = 1'b0;
        if (in0_valid && in1_valid) begin
            gnt_idx = pri_q;
        end else if (in1_valid) begin
            gnt_idx = 1'b1;
        end
    end

    // Ready comes from registered count only, so a pop cannot free a slot for
    // a push in the same cycle.
    assign in0_ready = !full && gnt_valid && (gnt_idx == 1'b0);
    assign in1_ready = !full && gnt_valid && (gnt_idx == 1'b1);

    assign push      = gnt_valid && !full;
    assign push_data = gnt_idx ? in1_data : in0_data;
    assign pop       = !empty && out_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pri_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {gnt_idx, push_data};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
                // The input just served loses the next contested cycle.
                pri_q           <= ~gnt_idx;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Head is forced to zero when empty so no stale entry is ever visible.
    always_comb begin
        out_valid = !empty;
        out_data  = '0;
        out_src   = 1'b0;
        if (!empty) begin
            out_data = mem_q[rd_ptr_q][W-1:0];
            out_src  = mem_q[rd_ptr_q][W];
        end
    end

`ifdef NOC_MERGE_STATS_EN
    logic [CNT_W-1:0] stat0_q;
    logic [CNT_W-1:0] stat1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else if (push) begin
            if (!gnt_idx && (stat0_q != '1)) begin
                stat0_q <= stat0_q + CNT_W'(1);
            end
            if (gnt_idx && (stat1_q != '1)) begin
                stat1_q <= stat1_q + CNT_W'(1);
            end
        end
    end

    assign stat0 = stat0_q;
    assign stat1 = stat1_q;
`endif

endmodule

// File: tb/tb_noc_merge2_arb.sv
// Directed self-checking bench for noc_merge2_arb. Inputs change and outputs
// are sampled 1-2 time units after the rising clock edge.

module tb_noc_merge2_arb;

    localparam int unsigned W = 9;

    logic         clk;
    logic         rst_n;
    logic         in0_valid;
    logic         in0_ready;
    logic [W-1:0] in0_data;
    logic         in1_valid;
    logic         in1_ready;
    logic [W-1:0] in1_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_src;
`ifdef NOC_MERGE_STATS_EN
    logic [15:0]  stat0;
    logic [15:0]  stat1;
`endif

    int n_pass;
    int n_total;

    noc_merge2_arb #(
        .W     (9),
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
`ifdef NOC_MERGE_STATS_EN
        ,
        .stat0     (stat0),
        .stat1     (stat1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 9'h000 || out_src !== 1'b0) begin
            $display("FAIL reset_out: got v=%b d=%h s=%b, need v=0 d=000 s=0",
                     out_valid, out_data, out_src);
        end else n_pass++;
        in0_valid = 1'b1;
        #1;
        n_total++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            $display("FAIL reset_ready: got r0=%b r1=%b, need r0=1 r1=0", in0_ready, in1_ready);
        end else n_pass++;
        in0_valid = 1'b0;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        in0_valid = 1'b1;
        in0_data  = 9'h0C5;
        out_ready = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL single_no_comb: got out_valid=%b, need 0", out_valid);
        end else n_pass++;
        step();
        in0_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 9'h0C5 || out_src !== 1'b0) begin
            $display("FAIL single_out: got v=%b d=%h s=%b, need v=1 d=0c5 s=0",
                     out_valid, out_data, out_src);
        end else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 9'h000) begin
            $display("FAIL single_drained: got v=%b d=%h, need v=0 d=000", out_valid, out_data);
        end else n_pass++;
    endtask

    task automatic test_alternate();
        logic [W-1:0] prev_data;
        logic         prev_src;
        logic         exp_src;
        do_reset();
        out_ready = 1'b1;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        prev_data = '0;
        prev_src  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_src  = k[0];
            in0_data = 9'h001 + 9'(k / 2 + (k % 2));
            in1_data = 9'h101 + 9'(k / 2);
            #1;
            n_total++;
            if (in0_ready !== ~exp_src || in1_ready !== exp_src) begin
                $display("FAIL alt_grant[%0d]: got r0=%b r1=%b, need r0=%b r1=%b",
                         k, in0_ready, in1_ready, ~exp_src, exp_src);
            end else n_pass++;
            if (k > 0) begin
                n_total++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_src !== prev_src) begin
                    $display("FAIL alt_out[%0d]: got v=%b d=%h s=%b, need v=1 d=%h s=%b",
                             k, out_valid, out_data, out_src, prev_data, prev_src);
                end else n_pass++;
            end
            prev_data = exp_src ? in1_data : in0_data;
            prev_src  = exp_src;
            step();
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        step();
    endtask

    task automatic test_fill_drain();
        do_reset();
        in1_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            in1_data = 9'h1A0 + 9'(n);
            #1;
            n_total++;
            if (in1_ready !== 1'b1) begin
                $display("FAIL fill_ready[%0d]: got in1_ready=%b, need 1", n, in1_ready);
            end else n_pass++;
            step();
        end
        in1_data = 9'h1A4;
        #1;
        n_total++;
        if (in1_ready !== 1'b0) begin
            $display("FAIL fill_full: got in1_ready=%b, need 0", in1_ready);
        end else n_pass++;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            n_total++;
            if (out_valid !== 1'b1 || out_data !== (9'h1A0 + 9'(n)) || out_src !== 1'b1) begin
                $display("FAIL drain[%0d]: got v=%b d=%h s=%b, need v=1 d=%h s=1",
                         n, out_valid, out_data, out_src, 9'h1A0 + 9'(n));
            end else n_pass++;
            step();
        end
        n_total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL drain_empty: got out_valid=%b, need 0", out_valid);
        end else n_pass++;
        in1_valid = 1'b1;
        #1;
        n_total++;
        if (in1_ready !== 1'b1) begin
            $display("FAIL drain_reready: got in1_ready=%b, need 1", in1_ready);
        end else n_pass++;
        in1_valid = 1'b0;
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_full_pop_push();
        do_reset();
        in0_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            in0_data = 9'h010 + 9'(n);
            step();
        end
        in0_data  = 9'h014;
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in0_ready !== 1'b0 || out_data !== 9'h010) begin
            $display("FAIL full_pop: got r0=%b d=%h, need r0=0 d=010", in0_ready, out_data);
        end else n_pass++;
        step();
        n_total++;
        if (in0_ready !== 1'b1 || out_data !== 9'h011) begin
            $display("FAIL full_after_pop: got r0=%b d=%h, need r0=1 d=011", in0_ready, out_data);
        end else n_pass++;
        step();
        in0_valid = 1'b0;
        for (int n = 2; n < 5; n++) begin
            #1;
            n_total++;
            if (out_valid !== 1'b1 || out_data !== (9'h010 + 9'(n))) begin
                $display("FAIL full_drain[%0d]: got v=%b d=%h, need v=1 d=%h",
                         n, out_valid, out_data, 9'h010 + 9'(n));
            end else n_pass++;
            step();
        end
        n_total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL full_empty: got out_valid=%b, need 0", out_valid);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in0_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            in0_data = 9'h020 + 9'(n);
            step();
        end
        in0_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 9'h020) begin
            $display("FAIL mid_queued: got v=%b d=%h, need v=1 d=020", out_valid, out_data);
        end else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 9'h000 || out_src !== 1'b0) begin
            $display("FAIL mid_async: got v=%b d=%h s=%b, need v=0 d=000 s=0",
                     out_valid, out_data, out_src);
        end else n_pass++;
        #2;
        rst_n = 1'b1;
        step();
        in1_valid = 1'b1;
        in1_data  = 9'h0AA;
        out_ready = 1'b1;
        step();
        in1_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 9'h0AA || out_src !== 1'b1) begin
            $display("FAIL mid_new: got v=%b d=%h s=%b, need v=1 d=0aa s=1",
                     out_valid, out_data, out_src);
        end else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL mid_no_stale: got out_valid=%b, need 0", out_valid);
        end else n_pass++;
    endtask

`ifdef NOC_MERGE_STATS_EN
    task automatic test_stats();
        do_reset();
        n_total++;
        if (stat0 !== 16'h0000 || stat1 !== 16'h0000) begin
            $display("FAIL stats_reset: got s0=%h s1=%h, need 0000 0000", stat0, stat1);
        end else n_pass++;
        in0_valid = 1'b1;
        in0_data  = 9'h033;
        out_ready = 1'b1;
        for (int n = 0; n < 70000; n++) begin
            step();
        end
        in0_valid = 1'b0;
        n_total++;
        if (stat0 !== 16'hFFFF || stat1 !== 16'h0000) begin
            $display("FAIL stats_sat: got s0=%h s1=%h, need ffff 0000", stat0, stat1);
        end else n_pass++;
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single();
        test_alternate();
        test_fill_drain();
        test_full_pop_push();
        test_reset_mid();
`ifdef NOC_MERGE_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
